minirv_lsu: RTL and testbench
=============================

# minirv_lsu

Load/store unit for the miniRV core: the initiator side of the data-memory port. It takes one LW/LBU/SW/SB request from the execute stage and issues it to a word-addressed memory over a req/gnt/rvalid handshake. It generates byte masks and lane-replicated store data, and returns zero-extended load data. While a transaction is in flight it stalls the core, so the core can use a multi-cycle or arbitrated data memory instead of a combinational one.

## Interface
Parameters: none.

Ports (all single-clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  execute stage presents a memory op this cycle
- ex_load  in  1  load request (LW/LBU)
- ex_store  in  1  store request (SW/SB)
- ex_byte  in  1  byte op (LBU/SB) when 1, word op when 0
- ex_addr  in  32  byte address
- ex_wdata  in  32  store data (SB uses [7:0])
- lsu_busy  out  1  stall core (combinational)
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  one-cycle misalign/illegal pulse, coincident with lsu_done
- lsu_rdata  out  32  load result, valid while lsu_done=1
- mem_req  out  1  request, held until mem_gnt
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  word-aligned address {ex_addr[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_wmask  out  4  byte-lane write enables
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE, when ex_valid=1 and exactly one of ex_load/ex_store is set, and the op is legal:
  - Register the request.
  - Drive the mem_* registers.
  - Go to REQ.
- Illegal requests go from IDLE to DONE with err=1, rdata=0, and no memory transaction. An op is illegal when:
  - ex_load and ex_store are both 1, or
  - it is a word op with ex_addr[1:0]≠0.
- ex_valid with neither load nor store set is ignored.
- REQ:
  - mem_req=1 and all mem_* fields are held stable until mem_gnt.
  - On gnt, a store goes to DONE.
  - On gnt, a load goes to WAIT, or directly to DONE if mem_rvalid=1 in the same cycle.
- WAIT: on mem_rvalid, capture the formatted data and go to DONE. No timeout.
- DONE: lsu_done=1 for one cycle, then go to IDLE. ex_valid is not sampled in DONE.
- Store formatting:
  - SW: wmask=4'hF, wdata=ex_wdata.
  - SB: wmask=4'b0001<<ex_addr[1:0], wdata={4{ex_wdata[7:0]}}.
- Load formatting:
  - LW: rdata=mem_rdata.
  - LBU: rdata={24'b0, lane}, where lane = mem_rdata byte addr[1:0] (0→[7:0] … 3→[31:24]).
- Reads drive mem_wmask=0 and mem_we=0.
- lsu_busy = (IDLE & ex_valid & (ex_load|ex_store)) | REQ | WAIT. It is 0 in DONE, so the core advances that cycle.
- mem_rvalid or mem_gnt outside their expected states is ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, lsu_done=0, lsu_err=0, lsu_rdata=0, state=IDLE.
- All outputs except lsu_busy are registered.
- Accept at cycle T; mem_req asserts at T+1.
- Store, gnt at T+1: lsu_done at T+2, so 2-cycle minimum latency.
- Load, gnt at T+1 with rvalid at T+1: done at T+2.
- Load, gnt at T+1 with rvalid at T+2: done at T+3.
- Each cycle mem_gnt is withheld adds one cycle. Each cycle mem_rvalid is withheld adds one cycle.
- Illegal op accepted at T: lsu_done and lsu_err at T+1, and mem_req is never asserted.
- Back-to-back ops: the next accept is earliest at the cycle after DONE.
- Reset mid-transaction:
  - State returns to IDLE and mem_req drops at the reset edge.
  - No lsu_done is produced for the aborted op.
  - A late mem_rvalid after reset is ignored.
- lsu_rdata holds its value until the next load completes. It is zeroed on an error.

## Test plan
- SB of ex_wdata=0x000000AB to ex_addr=0x102, gnt immediate -> mem_addr=0x100, mem_wmask=4'b0100, mem_wdata=0xABABABAB, mem_we=1, lsu_done at T+2, lsu_busy=1 at T and T+1.
- LBU from 0x203, gnt at T+1, rvalid at T+3 with rdata=0xDEADBEEF -> WAIT holds 2 cycles, lsu_rdata=0x000000DE, lsu_done at T+4.
- LW from 0x300, gnt withheld 3 cycles -> mem_req and mem_addr=0x300 stable throughout; done 3 cycles later than the zero-wait case; rdata passes through unchanged.
- LW from 0x302 (misaligned) -> no mem_req; lsu_done=lsu_err=1 at T+1; lsu_rdata=0. Same response when ex_load and ex_store are both 1.
- rst asserted while in WAIT, then mem_rvalid pulses after reset -> all outputs at reset values, no lsu_done, state IDLE; a new SW to 0x10 then completes normally with wmask=4'hF.

Source files
------------

// File: rtl/minirv_lsu.sv
// miniRV load/store unit: issues one LW/LBU/SW/SB to a word-addressed data memory
// over a req/gnt/rvalid handshake and stalls the core while the access is in flight.
module minirv_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic        ex_byte,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        is_load;
  logic        is_byte;
  logic [1:0]  lane;
  logic        op_valid;
  logic        op_illegal;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    op_valid   = ex_valid & (ex_load | ex_store);
    op_illegal = (ex_load & ex_store) | (~ex_byte & (ex_addr[1:0] != 2'b00));
    lane_byte  = mem_rdata[7:0];
    case (lane)
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      2'd3:    lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
    load_data = is_byte ? {24'b0, lane_byte} : mem_rdata;
  end

  // The stall must be visible in the same cycle the request is presented.
  assign lsu_busy = (state == IDLE && op_valid) || state == REQ || state == WAIT;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_load   <= 1'b0;
      is_byte   <= 1'b0;
      lane      <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= 32'd0;
    end else begin
      lsu_done <= 1'b0;
      lsu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (op_illegal) begin
              state     <= DONE;
              lsu_done  <= 1'b1;
              lsu_err   <= 1'b1;
              lsu_rdata <= 32'd0;
            end else begin
              state    <= REQ;
              is_load  <= ex_load;
              is_byte  <= ex_byte;
              lane     <= ex_addr[1:0];
              mem_req  <= 1'b1;
              mem_we   <= ex_store;
              mem_addr <= {ex_addr[31:2], 2'b00};
              if (ex_store) begin
                mem_wmask <= ex_byte ? (4'b0001 << ex_addr[1:0]) : 4'hF;
                mem_wdata <= ex_byte ? {4{ex_wdata[7:0]}} : ex_wdata;
              end else begin
                mem_wmask <= 4'd0;
                mem_wdata <= 32'd0;
              end
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (!is_load) begin
              state    <= DONE;
              lsu_done <= 1'b1;
            end else if (mem_rvalid) begin
              state     <= DONE;
              lsu_done  <= 1'b1;
              lsu_rdata <= load_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state     <= DONE;
            lsu_done  <= 1'b1;
            lsu_rdata <= load_data;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minirv_lsu.sv
// Self-checking bench for minirv_lsu: directed scenarios plus randomized ops against
// a word-array memory model with spec-derived masks, data and latencies.
module tb_minirv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store, ex_byte;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_model [logic [29:0]];
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  minirv_lsu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_byte(ex_byte),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_word(input logic [29:0] widx);
    if (!mem_model.exists(widx)) mem_model[widx] = $urandom;
    return mem_model[widx];
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_byte = 1'b0;
    ex_addr = 32'd0; ex_wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   mem_req,   0);
    check({tag, "_we"},    mem_we,    0);
    check({tag, "_addr"},  mem_addr,  0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_wmask"}, mem_wmask, 0);
    check({tag, "_done"},  lsu_done,  0);
    check({tag, "_err"},   lsu_err,   0);
    check({tag, "_rdata"}, lsu_rdata, 0);
    check({tag, "_busy"},  lsu_busy,  0);
  endtask

  // One complete op: gd = cycles gnt is withheld, rd = cycles from gnt to rvalid.
  task automatic do_op(input logic ld, input logic st, input logic by,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int gd, input int rd);
    logic        illegal;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata, word, e_load;
    int          e_lat, k, req_seen, gnt_k;
    bit          got_done;

    illegal = (ld && st) || (!by && addr[1:0] != 2'b00);
    e_mask  = !st ? 4'h0 : (by ? 4'(1 << addr[1:0]) : 4'hF);
    e_wdata = by ? {4{wd[7:0]}} : wd;
    word    = get_word(addr[31:2]);
    e_load  = by ? ((word >> (8 * addr[1:0])) & 32'hFF) : word;
    e_lat   = illegal ? 1 : (ld ? 2 + gd + rd : 2 + gd);

    @(negedge clk);
    check("idle_done_low", lsu_done, 0);
    check("idle_rdata_hold", lsu_rdata, exp_rdata);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_byte = by;
    ex_addr = addr; ex_wdata = wd;
    #1 check("busy_accept", lsu_busy, 1);

    k = 0; req_seen = 0; gnt_k = -1; got_done = 0;
    while (!got_done && k < 60) begin
      @(negedge clk);
      k++;
      ex_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (lsu_done) begin
        got_done = 1;
        check("done_latency", k, e_lat);
        check("done_err", lsu_err, illegal);
        check("done_busy", lsu_busy, 0);
        if (illegal) exp_rdata = 32'd0;
        else if (ld) exp_rdata = e_load;
        check("done_rdata", lsu_rdata, exp_rdata);
      end else begin
        check("busy_inflight", lsu_busy, 1);
        if (illegal) check("illegal_no_req", mem_req, 0);
        if (mem_req) begin
          if (req_seen == 0) check("req_first_cycle", k, 1);
          check("req_addr", mem_addr, {addr[31:2], 2'b00});
          check("req_we", mem_we, st);
          check("req_wmask", mem_wmask, e_mask);
          if (st) check("req_wdata", mem_wdata, e_wdata);
          req_seen++;
          if (req_seen == gd + 1) begin mem_gnt = 1'b1; gnt_k = k; end
        end
        if (ld && !illegal && gnt_k >= 0 && k == gnt_k + rd) begin
          mem_rvalid = 1'b1; mem_rdata = word;
        end
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    if (!illegal && st)
      for (int i = 0; i < 4; i++)
        if (e_mask[i]) mem_model[addr[31:2]][8*i +: 8] = e_wdata[8*i +: 8];
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    // Op with neither load nor store is ignored.
    @(negedge clk);
    ex_valid = 1'b1; ex_addr = 32'h44;
    #1 check("nop_busy", lsu_busy, 0);
    @(negedge clk);
    check("nop_req", mem_req, 0);
    check("nop_done", lsu_done, 0);
    ex_valid = 1'b0;

    do_op(0, 1, 1, 32'h102, 32'h000000AB, 0, 0);          // SB lane 2
    mem_model[30'h200 >> 2] = 32'hDEADBEEF;
    do_op(1, 0, 1, 32'h203, 32'h0, 0, 2);                 // LBU lane 3, rvalid 2 late
    do_op(1, 0, 0, 32'h300, 32'h0, 3, 0);                 // LW with gnt withheld 3
    do_op(1, 0, 0, 32'h302, 32'h0, 0, 0);                 // misaligned LW
    do_op(1, 0, 0, 32'h300, 32'h0, 0, 1);                 // restore nonzero rdata
    do_op(1, 1, 0, 32'h300, 32'h0, 0, 0);                 // load and store together
    do_op(0, 1, 0, 32'h301, 32'h12345678, 0, 0);          // misaligned SW
    do_op(1, 0, 1, 32'h102, 32'h0, 1, 0);                 // read back SB lane

    // Reset while a load waits for rvalid; a late rvalid must be ignored.
    do_op(1, 0, 0, 32'h40, 32'h0, 0, 0);
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_byte = 1'b0; ex_addr = 32'h40;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rst_seq_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rst_seq_wait_busy", lsu_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'd0;
    check_reset_values("midrst");
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("late_rvalid_done", lsu_done, 0);
      check("late_rvalid_rdata", lsu_rdata, 0);
      check("late_rvalid_busy", lsu_busy, 0);
    end
    do_op(0, 1, 0, 32'h10, 32'hCAFEF00D, 0, 0);            // SW after reset
    do_op(1, 0, 0, 32'h10, 32'h0, 2, 3);                   // read it back

    for (int n = 0; n < 60; n++) begin
      logic        ld, st, by;
      logic [31:0] a;
      int          kind;
      kind = $urandom_range(0, 8);
      ld = (kind inside {0, 1, 8});
      st = (kind inside {2, 3, 8});
      by = (kind inside {1, 3}) || (kind >= 4 && kind <= 7) || ($urandom_range(0, 1) == 1 && kind == 8);
      if (kind >= 4 && kind <= 7) begin ld = (kind < 6); st = !ld; end
      a = {24'h0, 2'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if (!by && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      do_op(ld, st, by, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
